// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - single-channel block copy/fill initiator on the CPU data memory port
// Outputs decode from registered state only; no combinational start-to-memory path.
module mem_dma #(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ADDR_WIDTH-1:0]      src_addr,
  input  logic [ADDR_WIDTH-1:0]      dst_addr,
  input  logic [ADDR_WIDTH:0]        len,
  input  logic [DATA_PATH_WIDTH-1:0] fill_value,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_wen,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_PATH_WIDTH-1:0] mem_wdata,
  input  logic [DATA_PATH_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]      src_ptr;
  logic [ADDR_WIDTH-1:0]      dst_ptr;
  logic [ADDR_WIDTH:0]        count;
  logic [DATA_PATH_WIDTH-1:0] data_buf;
  logic [DATA_PATH_WIDTH-1:0] fill_word;
  logic                       fill_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      count     <= '0;
      data_buf  <= '0;
      fill_word <= '0;
      fill_mode <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            count     <= len;
            fill_word <= fill_value;
            fill_mode <= mode;
          end
        end
        READ: begin
          data_buf <= mem_rdata;
          src_ptr  <= src_ptr + ADDR_WIDTH'(1);
        end
        WRITE: begin
          dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
          count   <= count - (ADDR_WIDTH + 1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)  state_nxt = DONE;
          else if (mode)  state_nxt = WRITE;
          else            state_nxt = READ;
        end
      end
      READ:  state_nxt = WRITE;
      WRITE: begin
        // count still holds the pre-decrement value here
        if (count == (ADDR_WIDTH + 1)'(1)) state_nxt = DONE;
        else if (!fill_mode)               state_nxt = READ;
        else                               state_nxt = WRITE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      READ: mem_addr = src_ptr;
      WRITE: begin
        mem_wen   = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = fill_mode ? fill_word : data_buf;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
